// File: rtl/showcase_ram_arbiter.sv
// Two-requester round-robin arbiter owning a small single-port synchronous RAM.
// One access per cycle; read data returns on the owner's response port one cycle later.
module showcase_ram_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_vld,
  output logic                  req0_rd,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  resp0_vld,
  output logic [DATA_WIDTH-1:0] resp0_data,
  input  logic                  req1_vld,
  output logic                  req1_rd,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  resp1_vld,
  output logic [DATA_WIDTH-1:0] resp1_data
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  logic                  prio_q, prio_d;
  logic                  gnt0, gnt1;
  logic                  acc_we;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  resp0_vld_q, resp0_vld_d;
  logic                  resp1_vld_q, resp1_vld_d;
  logic [DATA_WIDTH-1:0] resp0_data_q, resp0_data_d;
  logic [DATA_WIDTH-1:0] resp1_data_q, resp1_data_d;

  // Grants are suppressed during reset so no transfer can occur in a reset cycle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0_vld && req1_vld) begin
        gnt0 = !prio_q;
        gnt1 = prio_q;
      end else begin
        gnt0 = req0_vld;
        gnt1 = req1_vld;
      end
    end
  end

  assign req0_rd = gnt0;
  assign req1_rd = gnt1;

  always_comb begin
    acc_we    = req0_we;
    acc_addr  = req0_addr;
    acc_wdata = req0_wdata;
    if (gnt1) begin
      acc_we    = req1_we;
      acc_addr  = req1_addr;
      acc_wdata = req1_wdata;
    end
  end

  assign rd_word = mem_q[acc_addr];

  always_comb begin
    prio_d = prio_q;
    if (gnt0) begin
      prio_d = 1'b1;
    end else if (gnt1) begin
      prio_d = 1'b0;
    end
    resp0_vld_d  = gnt0 && !acc_we;
    resp1_vld_d  = gnt1 && !acc_we;
    resp0_data_d = resp0_vld_d ? rd_word : resp0_data_q;
    resp1_data_d = resp1_vld_d ? rd_word : resp1_data_q;
  end

  // A read accepted just before reset still pulses: its flop loads while rst is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q       <= 1'b0;
      resp0_vld_q  <= 1'b0;
      resp1_vld_q  <= 1'b0;
      resp0_data_q <= '0;
      resp1_data_q <= '0;
    end else begin
      prio_q       <= prio_d;
      resp0_vld_q  <= resp0_vld_d;
      resp1_vld_q  <= resp1_vld_d;
      resp0_data_q <= resp0_data_d;
      resp1_data_q <= resp1_data_d;
    end
  end

  // RAM contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if ((gnt0 || gnt1) && acc_we) begin
      mem_q[acc_addr] <= acc_wdata;
    end
  end

  assign resp0_vld  = resp0_vld_q;
  assign resp1_vld  = resp1_vld_q;
  assign resp0_data = resp0_data_q;
  assign resp1_data = resp1_data_q;

endmodule
